// File: rtl/fir_ctrl_sequencer.sv
// FIR front-end controller: sample strobe prescaler, sample-aligned coefficient
// reload sequencer and fixed-latency output capture.
module fir_ctrl_sequencer #(
  parameter int unsigned DIV     = 20,
  parameter int unsigned NUM_TAP = 33,
  parameter int unsigned COEF_W  = 10,
  parameter int unsigned ADDR_W  = 6,
  parameter int unsigned OUT_LAT = 2
) (
  input  logic              iClk_12MHz,
  input  logic              iRst,
  input  logic              iEnable,
  input  logic              iCoefUpdReq,
  input  logic [COEF_W-1:0] iCoefData,
  output logic [ADDR_W-1:0] oCoefRdAddr,
  output logic              oCoefWrEn,
  output logic [ADDR_W-1:0] oCoefWrAddr,
  output logic [COEF_W-1:0] oCoefWrData,
  output logic              oCoefUpdBusy,
  output logic              oCoefUpdDone,
  output logic              oEnSample_600kHz,
  input  logic [15:0]       iFirOut,
  output logic [15:0]       oFirOut,
  output logic              oFirOutValid
);

  localparam int unsigned CNT_W = $clog2(DIV);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_GAP = 2'd1,
    LOAD     = 2'd2,
    DONE     = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W:0]     tap_q, tap_d;
  logic                gap_hit_q, gap_hit_d;
  logic                strobe_q, strobe_d;
  logic [OUT_LAT-1:0]  lat_q, lat_d;
  logic [15:0]         fir_q, fir_d;
  logic                wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;

  logic                raw_strobe;
  logic                rd_active;

  always_comb begin
    raw_strobe = iEnable && (cnt_q == CNT_W'(DIV - 1));
    if (!iEnable || raw_strobe) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // gap_hit marks a strobe raised while already waiting, so a request that
  // coincides with a strobe in IDLE waits for the following one.
  always_comb begin
    state_d   = state_q;
    tap_d     = '0;
    gap_hit_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (iCoefUpdReq) begin
          state_d = iEnable ? WAIT_GAP : LOAD;
        end
      end
      WAIT_GAP: begin
        gap_hit_d = raw_strobe;
        if (!iEnable || gap_hit_q) begin
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (tap_q == (ADDR_W+1)'(NUM_TAP)) begin
          state_d = DONE;
        end else begin
          tap_d = tap_q + (ADDR_W+1)'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    rd_active   = (state_q == LOAD) && (tap_q < (ADDR_W+1)'(NUM_TAP));
    oCoefRdAddr = rd_active ? tap_q[ADDR_W-1:0] : '0;
    wr_en_d     = rd_active;
    wr_addr_d   = rd_active ? tap_q[ADDR_W-1:0] : '0;
  end

  // Mask against the state the strobe will be presented in, keeping the
  // output fully registered.
  always_comb begin
    strobe_d = raw_strobe && !((state_d == LOAD) || (state_d == DONE));
    lat_d    = '0;
    lat_d[0] = strobe_q;
    for (int unsigned i = 1; i < OUT_LAT; i++) begin
      lat_d[i] = lat_q[i-1];
    end
    fir_d = lat_d[OUT_LAT-1] ? iFirOut : fir_q;
  end

  always_ff @(posedge iClk_12MHz or posedge iRst) begin
    if (iRst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      tap_q     <= '0;
      gap_hit_q <= 1'b0;
      strobe_q  <= 1'b0;
      lat_q     <= '0;
      fir_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      tap_q     <= tap_d;
      gap_hit_q <= gap_hit_d;
      strobe_q  <= strobe_d;
      lat_q     <= lat_d;
      fir_q     <= fir_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
    end
  end

  always_comb begin
    oCoefWrEn        = wr_en_q;
    oCoefWrAddr      = wr_addr_q;
    oCoefWrData      = wr_en_q ? iCoefData : '0;
    oCoefUpdBusy     = (state_q != IDLE);
    oCoefUpdDone     = (state_q == DONE);
    oEnSample_600kHz = strobe_q;
    oFirOut          = fir_q;
    oFirOutValid     = lat_q[OUT_LAT-1];
  end

endmodule

// File: tb/tb_fir_ctrl_sequencer.sv
// Directed bench for fir_ctrl_sequencer: strobe grid, output capture,
// sample-aligned and disabled reloads, ignored requests, reset mid-reload.
module tb_fir_ctrl_sequencer;

  localparam int unsigned DIV     = 20;
  localparam int unsigned NUM_TAP = 33;
  localparam int unsigned COEF_W  = 10;
  localparam int unsigned ADDR_W  = 6;
  localparam int unsigned OUT_LAT = 2;
  localparam int          LD_LEN  = NUM_TAP + 1;

  logic              iClk_12MHz = 1'b0;
  logic              iRst;
  logic              iEnable;
  logic              iCoefUpdReq;
  logic [COEF_W-1:0] iCoefData;
  logic [ADDR_W-1:0] oCoefRdAddr;
  logic              oCoefWrEn;
  logic [ADDR_W-1:0] oCoefWrAddr;
  logic [COEF_W-1:0] oCoefWrData;
  logic              oCoefUpdBusy;
  logic              oCoefUpdDone;
  logic              oEnSample_600kHz;
  logic [15:0]       iFirOut;
  logic [15:0]       oFirOut;
  logic              oFirOutValid;

  fir_ctrl_sequencer #(
    .DIV     (DIV),
    .NUM_TAP (NUM_TAP),
    .COEF_W  (COEF_W),
    .ADDR_W  (ADDR_W),
    .OUT_LAT (OUT_LAT)
  ) dut (
    .iClk_12MHz       (iClk_12MHz),
    .iRst             (iRst),
    .iEnable          (iEnable),
    .iCoefUpdReq      (iCoefUpdReq),
    .iCoefData        (iCoefData),
    .oCoefRdAddr      (oCoefRdAddr),
    .oCoefWrEn        (oCoefWrEn),
    .oCoefWrAddr      (oCoefWrAddr),
    .oCoefWrData      (oCoefWrData),
    .oCoefUpdBusy     (oCoefUpdBusy),
    .oCoefUpdDone     (oCoefUpdDone),
    .oEnSample_600kHz (oEnSample_600kHz),
    .iFirOut          (iFirOut),
    .oFirOut          (oFirOut),
    .oFirOutValid     (oFirOutValid)
  );

  always #5 iClk_12MHz = ~iClk_12MHz;

  int          total = 0;
  int          bad   = 0;
  logic [15:0] fir_exp;
  int          wr_n, done_n, busy_n;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // One clock; coefficient source answers one clock after the address.
  task automatic cyc();
    logic [ADDR_W-1:0] a;
    a = oCoefRdAddr;
    @(posedge iClk_12MHz);
    #1;
    iCoefData = COEF_W'(a) + COEF_W'(100);
    @(negedge iClk_12MHz);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_rd"},     32'(oCoefRdAddr),      0);
    check({tag, "_wren"},   32'(oCoefWrEn),        0);
    check({tag, "_wraddr"}, 32'(oCoefWrAddr),      0);
    check({tag, "_wrdata"}, 32'(oCoefWrData),      0);
    check({tag, "_busy"},   32'(oCoefUpdBusy),     0);
    check({tag, "_done"},   32'(oCoefUpdDone),     0);
    check({tag, "_strobe"}, 32'(oEnSample_600kHz), 0);
    check({tag, "_fir"},    32'(oFirOut),          0);
    check({tag, "_valid"},  32'(oFirOutValid),     0);
  endtask

  function automatic bit strobe_at(input int i, input int ls, input bit grid);
    return grid && (i > 0) && (i % DIV == 0) && !((i >= ls) && (i <= ls + LD_LEN));
  endfunction

  // i counts clocks since the phase origin; ls = first LOAD cycle,
  // bf = first busy cycle, grid = strobes expected on the DIV grid.
  task automatic check_cycle(input int i, input int ls, input int bf, input bit grid);
    bit e_rd, e_wr;
    e_rd = (i >= ls) && (i <= ls + NUM_TAP - 1);
    e_wr = (i >= ls + 1) && (i <= ls + NUM_TAP);
    check($sformatf("strobe@%0d", i), 32'(oEnSample_600kHz), 32'(strobe_at(i, ls, grid)));
    check($sformatf("valid@%0d", i),  32'(oFirOutValid), 32'(strobe_at(i - OUT_LAT, ls, grid)));
    check($sformatf("fir@%0d", i),    32'(oFirOut), 32'(fir_exp));
    check($sformatf("busy@%0d", i),   32'(oCoefUpdBusy), 32'((i >= bf) && (i <= ls + LD_LEN)));
    check($sformatf("done@%0d", i),   32'(oCoefUpdDone), 32'(i == ls + LD_LEN));
    check($sformatf("rd@%0d", i),     32'(oCoefRdAddr), e_rd ? i - ls : 0);
    check($sformatf("wren@%0d", i),   32'(oCoefWrEn), 32'(e_wr));
    check($sformatf("wraddr@%0d", i), 32'(oCoefWrAddr), e_wr ? i - ls - 1 : 0);
    check($sformatf("wrdata@%0d", i), 32'(oCoefWrData), e_wr ? i - ls - 1 + 100 : 0);
  endtask

  task automatic run(input int n, input int ls, input int bf, input bit grid,
                     input int rq0, input int rq1, input int chg_at, input logic [15:0] chg_val);
    logic [15:0] fin;
    for (int i = 1; i <= n; i++) begin
      iCoefUpdReq = (i - 1 == rq0) || (i - 1 == rq1);
      if (i - 1 == chg_at) iFirOut = chg_val;
      fin = iFirOut;
      cyc();
      if (strobe_at(i - OUT_LAT, ls, grid)) fir_exp = fin;
      check_cycle(i, ls, bf, grid);
      if (oCoefWrEn)    wr_n++;
      if (oCoefUpdDone) done_n++;
      if (oCoefUpdBusy) busy_n++;
    end
    iCoefUpdReq = 1'b0;
  endtask

  initial begin
    iRst        = 1'b1;
    iEnable     = 1'b1;
    iCoefUpdReq = 1'b1;
    iCoefData   = '0;
    iFirOut     = 16'h1234;
    fir_exp     = 16'h0000;
    @(negedge iClk_12MHz);
    for (int k = 0; k < 3; k++) begin
      cyc();
      check_zero($sformatf("rst%0d", k));
    end

    // Free-running strobes and capture; reload requested at count 5.
    iRst        = 1'b0;
    iCoefUpdReq = 1'b0;
    run(130, 81, 66, 1'b1, 65, -1, 30, 16'h5678);

    // Disabled reload with a second request during LOAD.
    iEnable = 1'b0;
    wr_n = 0; done_n = 0; busy_n = 0;
    run(40, 1, 1, 1'b0, 0, 9, -1, 16'h0000);
    check("wr_count",   32'(wr_n),   NUM_TAP);
    check("done_count", 32'(done_n), 1);
    check("busy_count", 32'(busy_n), LD_LEN + 1);

    // Reset asserted at write of address 10.
    run(12, 1, 1, 1'b0, 0, -1, -1, 16'h0000);
    iRst = 1'b1;
    #1;
    check_zero("rst_mid");
    cyc();
    cyc();
    check_zero("rst_hold");

    // Restart: request coinciding with a raw strobe waits for the next one.
    iRst    = 1'b0;
    iEnable = 1'b1;
    iFirOut = 16'h2222;
    fir_exp = 16'h0000;
    run(90, 41, 20, 1'b1, 19, -1, -1, 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fir_ctrl_sequencer.md
Name: fir_ctrl_sequencer

Overview:
Controller that sits in front of the FIR filter datapath. It generates the 600 kHz sample strobe from the 12 MHz clock (divide by DIV). It sequences atomic reloads of the filter's coefficient memory from a coefficient source, aligned to sample boundaries, with sample strobes frozen during the reload. It also captures the filter output a fixed latency after each strobe and presents it with a valid pulse.

Parameters:
DIV, 20, clocks per sample strobe (12 MHz / 600 kHz); legal range 4..255
NUM_TAP, 33, coefficients per reload (addresses 0..NUM_TAP-1)
COEF_W, 10, coefficient width
ADDR_W, 6, coefficient address width; 2^ADDR_W >= NUM_TAP
OUT_LAT, 2, clocks from issued strobe to output capture; 1 <= OUT_LAT < DIV

Ports:
iClk_12MHz  in  1  system clock, 12 MHz
iRst  in  1  reset, asynchronous, active-high
iEnable  in  1  run enable for strobe generation
iCoefUpdReq  in  1  single-cycle request to reload coefficients
iCoefData  in  COEF_W  coefficient from source; valid 1 clock after oCoefRdAddr
oCoefRdAddr  out  ADDR_W  coefficient source read address
oCoefWrEn  out  1  filter coefficient memory write enable
oCoefWrAddr  out  ADDR_W  filter coefficient write address
oCoefWrData  out  COEF_W  filter coefficient write data
oCoefUpdBusy  out  1  high while reload is pending or in progress
oCoefUpdDone  out  1  single-cycle pulse at reload completion
oEnSample_600kHz  out  1  single-cycle sample strobe to the filter
iFirOut  in  16  filter output
oFirOut  out  16  captured filter output, held between captures
oFirOutValid  out  1  single-cycle pulse when oFirOut updates

Behaviour:
- Reset: every output is 0. Prescaler is 0 and the FSM is in IDLE. Async assert; deassertion takes effect on the next clock edge. Reset mid-reload aborts the reload with no Done pulse; the filter memory is left partially written.
- Prescaler: counts 0..DIV-1 and wraps while iEnable=1. It is held at 0 while iEnable=0.
- Strobe: raw strobe occurs when count==DIV-1 and iEnable=1. oEnSample_600kHz is the registered raw strobe, masked while the FSM is in LOAD or DONE. Masked strobes are dropped, not deferred. The prescaler keeps running during masking.
- FSM states: IDLE, WAIT_GAP, LOAD, DONE.
  - IDLE:
    - iCoefUpdReq=1 and iEnable=1 -> WAIT_GAP.
    - iCoefUpdReq=1 and iEnable=0 -> LOAD.
  - WAIT_GAP: leaves on the cycle oEnSample_600kHz=1 and enters LOAD on the next cycle, so the load starts immediately after a sample. If iEnable drops while in WAIT_GAP -> LOAD.
  - LOAD:
    - Read pointer r runs 0..NUM_TAP-1, one per clock, on oCoefRdAddr.
    - Write is delayed 1 clock: oCoefWrEn=1, oCoefWrAddr=r-1, oCoefWrData=iCoefData for NUM_TAP consecutive cycles.
    - LOAD lasts NUM_TAP+1 cycles. oCoefWrEn is registered and aligned with address and data.
  - DONE: 1 cycle, oCoefUpdDone=1 -> IDLE.
- oCoefUpdBusy=1 in WAIT_GAP, LOAD and DONE.
- iCoefUpdReq while busy is ignored, not queued. A request arriving in the same cycle as a raw strobe, in IDLE, still goes to WAIT_GAP and waits for the next strobe.
- Output capture:
  - A delay counter/shift of depth OUT_LAT tracks issued (unmasked) strobes.
  - OUT_LAT clocks after an issued strobe: oFirOut <= iFirOut and oFirOutValid=1 for one cycle.
  - No capture occurs for masked strobes.
  - A strobe issued just before LOAD entry still completes its capture during LOAD.
- Read/write addresses outside a LOAD are 0. oCoefWrData is 0 when oCoefWrEn=0.

Test Plan:
- Reset then iEnable=1, DIV=20 -> first oEnSample_600kHz 20 clocks after enable, then exactly every 20 clocks. Outputs 0 during reset.
- iEnable=1, iFirOut=16'h1234 constant -> oFirOutValid pulses 2 clocks after each strobe with oFirOut=16'h1234. oFirOut holds between pulses.
- iCoefUpdReq at count 5 with source data = address+100:
  - Busy rises the next cycle.
  - LOAD starts the cycle after the next strobe.
  - 33 writes occur at addr 0..32 with data 100..132.
  - The Done pulse follows.
  - Strobes are absent from LOAD entry to Done and resume on the original 20-clock grid.
- iEnable=0 with iCoefUpdReq -> LOAD starts the next cycle. Total busy is 35 cycles; no strobes occur.
- Second iCoefUpdReq during LOAD -> ignored. Exactly 33 writes, one Done pulse.
- Assert iRst at LOAD write 10 -> all outputs 0 immediately. After release: IDLE, no Done, strobe count restarts from 0.
